// File: rtl/segway_pkg.sv
// Shared Segway types: SPI arbiter state encoding, owner encoding and the
// response word substituted when a transaction is aborted by the watchdog.
package segway_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_BUSY,
    ARB_GAP
  } arb_state_e;

  localparam logic [15:0] RESP_TMO  = 16'hDEAD;
  localparam logic        OWN_INERT = 1'b0;
  localparam logic        OWN_A2D   = 1'b1;

  // Round-robin pick: on a tie the requester that did not go last wins.
  function automatic logic pick_owner(input logic inert_req,
                                      input logic a2d_req,
                                      input logic last);
    if (inert_req && a2d_req) return ~last;
    return a2d_req ? OWN_A2D : OWN_INERT;
  endfunction

endpackage

// File: rtl/spi_bus_arb.sv
// Shares one SPI master between the inertial and A2D interfaces: round-robin
// grant, enforced SS_n idle gap, and a watchdog that aborts hung transactions.
module spi_bus_arb
  import segway_pkg::*;
#(
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inert_req,
  input  logic [15:0] inert_cmd,
  output logic        inert_done,
  output logic [15:0] inert_resp,
  input  logic        a2d_req,
  input  logic [15:0] a2d_cmd,
  output logic        a2d_done,
  output logic [15:0] a2d_resp,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_resp,
  output logic        sel,
  output logic        busy,
  output logic        tmo_err
);

  localparam int WD_W  = $clog2(TIMEOUT_CYC);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int CNT_W = (WD_W > GAP_W) ? WD_W : GAP_W;
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic [15:0]      spi_cmd_q, spi_cmd_d;
  logic             spi_wrt_q, spi_wrt_d;
  logic             busy_q, busy_d;
  logic             tmo_err_q, tmo_err_d;
  logic             inert_done_q, inert_done_d;
  logic [15:0]      inert_resp_q, inert_resp_d;
  logic             a2d_done_q, a2d_done_d;
  logic [15:0]      a2d_resp_q, a2d_resp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fin;
  logic [15:0]      fin_resp;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_d      = state_q;
    last_d       = last_q;
    sel_d        = sel_q;
    spi_cmd_d    = spi_cmd_q;
    spi_wrt_d    = 1'b0;
    tmo_err_d    = tmo_err_q;
    inert_done_d = 1'b0;
    inert_resp_d = inert_resp_q;
    a2d_done_d   = 1'b0;
    a2d_resp_d   = a2d_resp_q;
    cnt_d        = cnt_q;
    fin          = 1'b0;
    fin_resp     = spi_resp;

    unique case (state_q)
      ARB_IDLE: begin
        if (inert_req || a2d_req) begin
          sel_d     = pick_owner(inert_req, a2d_req, last_q);
          last_d    = sel_d;
          spi_cmd_d = (sel_d == OWN_A2D) ? a2d_cmd : inert_cmd;
          spi_wrt_d = 1'b1;
          state_d   = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        cnt_d   = '0;
        state_d = ARB_BUSY;
      end
      ARB_BUSY: begin
        // A spi_done landing on the expiry clock is a normal completion.
        if (spi_done) begin
          fin = 1'b1;
        end else if (cnt_q == WD_LAST) begin
          fin       = 1'b1;
          fin_resp  = RESP_TMO;
          tmo_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_GAP: begin
        if (cnt_q == GAP_LAST) state_d = ARB_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (fin) begin
      cnt_d   = '0;
      state_d = ARB_GAP;
      if (sel_q == OWN_A2D) begin
        a2d_resp_d = fin_resp;
        a2d_done_d = 1'b1;
      end else begin
        inert_resp_d = fin_resp;
        inert_done_d = 1'b1;
      end
    end

    busy_d = (state_d != ARB_IDLE);
  end

  // NOTE: state updates use non-blocking assignments and the reset is sampled
  // on the clock edge, so a mid-transaction reset aborts straight to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_q       <= OWN_A2D;
      sel_q        <= 1'b0;
      spi_cmd_q    <= '0;
      spi_wrt_q    <= 1'b0;
      busy_q       <= 1'b0;
      tmo_err_q    <= 1'b0;
      inert_done_q <= 1'b0;
      inert_resp_q <= '0;
      a2d_done_q   <= 1'b0;
      a2d_resp_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      sel_q        <= sel_d;
      spi_cmd_q    <= spi_cmd_d;
      spi_wrt_q    <= spi_wrt_d;
      busy_q       <= busy_d;
      tmo_err_q    <= tmo_err_d;
      inert_done_q <= inert_done_d;
      inert_resp_q <= inert_resp_d;
      a2d_done_q   <= a2d_done_d;
      a2d_resp_q   <= a2d_resp_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sel        = sel_q;
  assign spi_cmd    = spi_cmd_q;
  assign spi_wrt    = spi_wrt_q;
  assign busy       = busy_q;
  assign tmo_err    = tmo_err_q;
  assign inert_done = inert_done_q;
  assign inert_resp = inert_resp_q;
  assign a2d_done   = a2d_done_q;
  assign a2d_resp   = a2d_resp_q;

endmodule

// File: tb/tb_spi_bus_arb.sv
// Directed bench for spi_bus_arb: single requester, round-robin alternation,
// withdrawn request, watchdog abort and its boundary, and mid-transaction reset.
module tb_spi_bus_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inert_req = 1'b0;
  logic [15:0] inert_cmd = '0;
  logic        inert_done;
  logic [15:0] inert_resp;
  logic        a2d_req = 1'b0;
  logic [15:0] a2d_cmd = '0;
  logic        a2d_done;
  logic [15:0] a2d_resp;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done = 1'b0;
  logic [15:0] spi_resp = '0;
  logic        sel;
  logic        busy;
  logic        tmo_err;

  int total = 0;
  int bad   = 0;
  int inert_cnt = 0;
  int a2d_cnt   = 0;
  int wrt_cnt   = 0;

  spi_bus_arb #(.GAP_CYC(4), .TIMEOUT_CYC(2048)) dut (
    .clk(clk), .rst_n(rst_n),
    .inert_req(inert_req), .inert_cmd(inert_cmd),
    .inert_done(inert_done), .inert_resp(inert_resp),
    .a2d_req(a2d_req), .a2d_cmd(a2d_cmd),
    .a2d_done(a2d_done), .a2d_resp(a2d_resp),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_resp(spi_resp),
    .sel(sel), .busy(busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (inert_done) inert_cnt <= inert_cnt + 1;
    if (a2d_done)   a2d_cnt   <= a2d_cnt + 1;
    if (spi_wrt)    wrt_cnt   <= wrt_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no_finish want finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wrt"},   spi_wrt,    0);
    check({tag, "_busy"},  busy,       0);
    check({tag, "_sel"},   sel,        0);
    check({tag, "_idone"}, inert_done, 0);
    check({tag, "_adone"}, a2d_done,   0);
    check({tag, "_tmo"},   tmo_err,    0);
    check({tag, "_cmd"},   spi_cmd,    0);
    check({tag, "_iresp"}, inert_resp, 0);
    check({tag, "_aresp"}, a2d_resp,   0);
  endtask

  // One transaction as the SPI master sees it. Returns one clock after the
  // owner's done pulse, with the owner's req already dropped.
  task automatic serve(input string tag, input logic exp_sel, input logic [15:0] exp_cmd,
                       input logic [15:0] resp, input int delay, input int exp_wait,
                       input logic poke_a2d, input logic exp_tmo);
    int w;
    w = 0;
    while (spi_wrt !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_wrt"}, spi_wrt, 1);
    if (exp_wait >= 0) check({tag, "_lat"}, w, exp_wait);
    check({tag, "_cmd"},  spi_cmd, exp_cmd);
    check({tag, "_sel"},  sel,     exp_sel);
    check({tag, "_busy"}, busy,    1);
    tick();
    check({tag, "_wrt1"}, spi_wrt, 0);
    for (int i = 1; i < delay; i++) begin
      if (poke_a2d && i == 5)  a2d_req = 1'b1;
      if (poke_a2d && i == 10) a2d_req = 1'b0;
      tick();
    end
    spi_done = 1'b1;
    spi_resp = resp;
    tick();
    spi_done = 1'b0;
    spi_resp = 16'h0;
    check({tag, "_done"},  exp_sel ? a2d_done : inert_done, 1);
    check({tag, "_other"}, exp_sel ? inert_done : a2d_done, 0);
    check({tag, "_resp"},  exp_sel ? a2d_resp : inert_resp, resp);
    check({tag, "_tmo"},   tmo_err, exp_tmo);
    if (exp_sel) a2d_req = 1'b0;
    else         inert_req = 1'b0;
    tick();
    check({tag, "_pulse"}, exp_sel ? a2d_done : inert_done, 0);
    check({tag, "_gap"},   busy, 1);
  endtask

  initial begin
    int w;
    int snap_a2d;
    int snap_wrt;
    int snap_inert;
    logic        exp_sel;
    logic [15:0] rv;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Inertial alone
    inert_cmd = 16'h8F00;
    inert_req = 1'b1;
    serve("solo", 1'b0, 16'h8F00, 16'h00A5, 40, 1, 1'b0, 1'b0);
    repeat (8) tick();
    check("solo_a2dcnt", a2d_cnt, 0);
    check("solo_wrtcnt", wrt_cnt, 1);
    check("solo_icnt",   inert_cnt, 1);
    check("solo_idle",   busy, 0);

    // Fresh reset, then both requesting: strict alternation starting inertial
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    inert_cmd = 16'h1111;
    a2d_cmd   = 16'h2222;
    inert_req = 1'b1;
    a2d_req   = 1'b1;
    for (int r = 0; r < 10; r++) begin
      exp_sel = r[0];
      rv = 16'hA000 + 16'(r);
      serve("rr", exp_sel, exp_sel ? 16'h2222 : 16'h1111, rv, 3 + r,
            (r == 0) ? 1 : 4, 1'b0, 1'b0);
      if (exp_sel) a2d_req = 1'b1;
      else         inert_req = 1'b1;
    end
    inert_req = 1'b0;
    a2d_req   = 1'b0;
    repeat (8) tick();
    check("rr_idle", busy, 0);

    // A2D request raised and withdrawn during an inertial transaction
    inert_cmd = 16'h3333;
    inert_req = 1'b1;
    snap_a2d  = a2d_cnt;
    serve("wd", 1'b0, 16'h3333, 16'h5A5A, 20, 1, 1'b1, 1'b0);
    snap_wrt = wrt_cnt;
    repeat (12) tick();
    check("wd_nowrt",  wrt_cnt, snap_wrt);
    check("wd_nodone", a2d_cnt, snap_a2d);
    check("wd_idle",   busy, 0);

    // spi_done on the same clock the watchdog would expire
    inert_cmd = 16'h4444;
    inert_req = 1'b1;
    serve("edge", 1'b0, 16'h4444, 16'h1234, 2048, 1, 1'b0, 1'b0);
    repeat (6) tick();

    // Hung transaction: watchdog abort after 2048 BUSY clocks
    inert_cmd = 16'h5555;
    inert_req = 1'b1;
    w = 0;
    while (spi_wrt !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("tmo_wrt", spi_wrt, 1);
    w = 0;
    while (inert_done !== 1'b1 && w < 2200) begin
      tick();
      w++;
    end
    check("tmo_cycles", w, 2049);
    check("tmo_done",   inert_done, 1);
    check("tmo_resp",   inert_resp, 16'hDEAD);
    check("tmo_err",    tmo_err, 1);
    check("tmo_adone",  a2d_done, 0);
    inert_req = 1'b0;
    tick();
    check("tmo_pulse", inert_done, 0);

    // Next request serviced normally, error stays sticky
    a2d_cmd = 16'h6666;
    a2d_req = 1'b1;
    serve("post", 1'b1, 16'h6666, 16'h0F0F, 10, -1, 1'b0, 1'b1);
    repeat (8) tick();
    check("post_sticky", tmo_err, 1);

    // Reset for one clock in the middle of BUSY
    inert_cmd = 16'h7777;
    inert_req = 1'b1;
    w = 0;
    while (spi_wrt !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("rst_wrt", spi_wrt, 1);
    repeat (5) tick();
    snap_inert = inert_cnt;
    rst_n     = 1'b0;
    inert_req = 1'b0;
    tick();
    check_all_zero("rst");
    rst_n    = 1'b1;
    spi_done = 1'b1;
    spi_resp = 16'hBEEF;
    tick();
    spi_done = 1'b0;
    spi_resp = 16'h0;
    repeat (3) tick();
    check("rst_nodone", inert_cnt, snap_inert);
    check("rst_idle",   busy, 0);
    check("rst_iresp",  inert_resp, 0);

    // After reset a tie goes to inertial, then A2D
    inert_cmd = 16'h8888;
    a2d_cmd   = 16'h9999;
    inert_req = 1'b1;
    a2d_req   = 1'b1;
    serve("tie_i", 1'b0, 16'h8888, 16'hC001, 6, 1, 1'b0, 1'b0);
    serve("tie_a", 1'b1, 16'h9999, 16'hC002, 6, 4, 1'b0, 1'b0);
    repeat (8) tick();
    check("tie_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
